// File: rtl/instruction_queue.sv
// Circular instruction queue between fetch and decode, with push/pop/flush control.
// Define IQ_BYPASS_EN to let an instruction pushed into an empty queue appear at the head in the same cycle.
module instruction_queue #(
    parameter int iq_size       = 8,
    parameter int iq_index_bits = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              inst_in,
    input  logic [31:0]              pc_in,
    input  logic                     load_iq,
    output logic                     iq_full,
    input  logic                     flush_iq,
    output logic [31:0]              instruction_iq_head,
    output logic [31:0]              PC_iq_head,
    output logic                     load_dec_iq,
    input  logic                     full_dec,
    output logic [iq_index_bits:0]   iq_count
);

    localparam logic [iq_index_bits:0] full_count = (iq_index_bits+1)'(iq_size);

    logic [31:0]              inst_mem [iq_size];
    logic [31:0]              pc_mem   [iq_size];

    logic [iq_index_bits-1:0] rd_ptr;
    logic [iq_index_bits-1:0] wr_ptr;
    logic [iq_index_bits:0]   count;

    logic                     empty;
    logic                     push_ok;
    logic                     do_write;
    logic                     queue_pop;
    logic                     bypass;

    assign empty    = (count == '0);
    assign iq_full  = (count == full_count);
    assign iq_count = count;

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot.
    assign push_ok   = load_iq && !iq_full && !flush_iq;
    assign queue_pop = !empty && !full_dec && !flush_iq;

`ifdef IQ_BYPASS_EN
    // rst gating keeps the head outputs at zero while reset is held.
    assign bypass   = rst && empty && load_iq && !flush_iq;
    assign do_write = push_ok && !(bypass && !full_dec);
`else
    assign bypass   = 1'b0;
    assign do_write = push_ok;
`endif

    always_comb begin
        instruction_iq_head = 32'h0;
        PC_iq_head          = 32'h0;
        load_dec_iq         = 1'b0;
        if (bypass) begin
            instruction_iq_head = inst_in;
            PC_iq_head          = pc_in;
            load_dec_iq         = 1'b1;
        end else if (!empty) begin
            instruction_iq_head = inst_mem[rd_ptr];
            PC_iq_head          = pc_mem[rd_ptr];
            load_dec_iq         = 1'b1;
        end
    end

    // Storage is deliberately left unreset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            inst_mem[wr_ptr] <= inst_in;
            pc_mem[wr_ptr]   <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_iq) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (queue_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, queue_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: driver queues expected head entries, negedge monitor checks pops.
module tb_instruction_queue;

    logic        clk;
    logic        rst;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        load_iq;
    logic        iq_full;
    logic        flush_iq;
    logic [31:0] instruction_iq_head;
    logic [31:0] PC_iq_head;
    logic        load_dec_iq;
    logic        full_dec;
    logic [3:0]  iq_count;

    int n_checks = 0;
    int n_fail   = 0;
    int mc       = 0;
    logic [63:0] sb[$];

    instruction_queue #(.iq_size(8), .iq_index_bits(3)) dut (
        .clk(clk),
        .rst(rst),
        .inst_in(inst_in),
        .pc_in(pc_in),
        .load_iq(load_iq),
        .iq_full(iq_full),
        .flush_iq(flush_iq),
        .instruction_iq_head(instruction_iq_head),
        .PC_iq_head(PC_iq_head),
        .load_dec_iq(load_dec_iq),
        .full_dec(full_dec),
        .iq_count(iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs and advance the reference model.
    task automatic set_in(input logic li, input logic [31:0] inst, input logic [31:0] pc,
                          input logic fd, input logic fl);
        logic push_ok, pop_ok;
        load_iq  = li;
        inst_in  = inst;
        pc_in    = pc;
        full_dec = fd;
        flush_iq = fl;
        push_ok  = li && !fl && (mc != 8);
`ifdef IQ_BYPASS_EN
        pop_ok   = !fl && !fd && ((mc != 0) || li);
`else
        pop_ok   = !fl && !fd && (mc != 0);
`endif
        if (fl) begin
            mc = 0;
            sb.delete();
        end else begin
            if (push_ok) sb.push_back({inst, pc});
            mc = mc + int'(push_ok) - int'(pop_ok);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic li, input logic [31:0] inst, input logic [31:0] pc,
                        input logic fd, input logic fl);
        set_in(li, inst, pc, fd, fl);
        tick();
    endtask

    // Monitor: every consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && !flush_iq && load_dec_iq && !full_dec) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc 0x%08h expected no valid head", PC_iq_head);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({instruction_iq_head, PC_iq_head} !== e) begin
                    n_fail++;
                    $display("FAIL head_order: got inst 0x%08h pc 0x%08h expected inst 0x%08h pc 0x%08h",
                             instruction_iq_head, PC_iq_head, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; inst_in = '0; pc_in = '0; load_iq = 1'b0; full_dec = 1'b0; flush_iq = 1'b0;
        #12;
        check("rst_count", 32'(iq_count), 32'd0);
        check("rst_full", 32'(iq_full), 32'd0);
        check("rst_valid", 32'(load_dec_iq), 32'd0);
        check("rst_inst", instruction_iq_head, 32'h0);
        check("rst_pc", PC_iq_head, 32'h0);
        rst = 1'b1;
        tick();

        // Fill with decoder stalled, then try a ninth push.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h13 + k, 32'h60 + 4 * k, 1'b1, 1'b0);
            check("fill_count", 32'(iq_count), k + 1);
        end
        check("fill_full", 32'(iq_full), 32'd1);
        check("fill_valid", 32'(load_dec_iq), 32'd1);
        step(1'b1, 32'hdeadbeef, 32'hdead0000, 1'b1, 1'b0);
        check("drop_count", 32'(iq_count), 32'd8);

        // Drain while pushing: first push dropped, then steady at seven.
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 32'h100 + j, 32'h200 + 4 * j, 1'b0, 1'b0);
            check("stream_count", 32'(iq_count), 32'd7);
        end
        check("stream_full", 32'(iq_full), 32'd0);

        for (int j = 0; j < 4; j++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pop4_count", 32'(iq_count), 32'd3);

        // Steady push/pop at depth three, wrapping both pointers.
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 32'h1000 + j, 32'h400 + 4 * j, 1'b0, 1'b0);
            check("wrap_count", 32'(iq_count), 32'd3);
        end
        for (int j = 0; j < 3; j++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("drain_count", 32'(iq_count), 32'd0);
        check("drain_valid", 32'(load_dec_iq), 32'd0);
        check("drain_head", instruction_iq_head, 32'h0);
        check("drain_sb_empty", sb.size(), 32'd0);

        // Flush with a competing push and pop.
        for (int k = 0; k < 5; k++) step(1'b1, 32'h2000 + k, 32'h800 + 4 * k, 1'b1, 1'b0);
        check("pre_flush_count", 32'(iq_count), 32'd5);
        step(1'b1, 32'h0badc0de, 32'h0bad0000, 1'b0, 1'b1);
        check("flush_count", 32'(iq_count), 32'd0);
        check("flush_valid", 32'(load_dec_iq), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("post_flush_count", 32'(iq_count), 32'd0);

        // Asynchronous reset between edges.
        for (int k = 0; k < 4; k++) step(1'b1, 32'h3000 + k, 32'hc00 + 4 * k, 1'b1, 1'b0);
        check("pre_rst_count", 32'(iq_count), 32'd4);
        load_iq = 1'b0;
        rst = 1'b0;
        mc = 0;
        sb.delete();
        #1;
        check("arst_count", 32'(iq_count), 32'd0);
        check("arst_full", 32'(iq_full), 32'd0);
        check("arst_valid", 32'(load_dec_iq), 32'd0);
        check("arst_inst", instruction_iq_head, 32'h0);
        check("arst_pc", PC_iq_head, 32'h0);
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_count", 32'(iq_count), 32'd0);

        // Push into an empty queue with the decoder ready.
        set_in(1'b1, 32'h00500093, 32'h00000300, 1'b0, 1'b0);
        #1;
`ifdef IQ_BYPASS_EN
        check("byp_inst", instruction_iq_head, 32'h00500093);
        check("byp_valid", 32'(load_dec_iq), 32'd1);
        tick();
        check("byp_count", 32'(iq_count), 32'd0);
`else
        check("nobyp_inst", instruction_iq_head, 32'h0);
        check("nobyp_valid", 32'(load_dec_iq), 32'd0);
        tick();
        check("nobyp_count", 32'(iq_count), 32'd1);
        check("nobyp_latency_valid", 32'(load_dec_iq), 32'd1);
        check("nobyp_latency_inst", instruction_iq_head, 32'h00500093);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("final_count", 32'(iq_count), 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001: Parameter iq_size, default 8, SHALL set queue depth in entries; power of two, at least 2.
REQ-002: Parameter iq_index_bits, default 3, SHALL equal log2(iq_size).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005: inst_in  input  32  SHALL carry the fetched instruction word.
REQ-006: pc_in  input  32  SHALL carry the PC of inst_in.
REQ-007: load_iq  input  1  SHALL request a push of {inst_in, pc_in}.
REQ-008: iq_full  output  1  SHALL be high when count == iq_size; fetch holds while high.
REQ-009: flush_iq  input  1  SHALL request discard of all entries (redirect/mispredict).
REQ-010: instruction_iq_head  output  32  SHALL carry the oldest instruction.
REQ-011: PC_iq_head  output  32  SHALL carry the PC of the oldest instruction.
REQ-012: load_dec_iq  output  1  SHALL be high when head outputs hold a valid instruction.
REQ-013: full_dec  input  1  SHALL be the decoder stall; high means the head is not consumed this cycle.
REQ-014: iq_count  output  iq_index_bits+1  SHALL give the current entry count.

Function
REQ-015: Storage SHALL be a circular buffer of iq_size entries of {inst, pc}, with read pointer, write pointer and count registers.
REQ-016: Push SHALL occur at the clock edge when load_iq=1 and iq_full=0: entry written at the write pointer, write pointer incremented modulo iq_size.
REQ-017: Pop SHALL occur at the clock edge when load_dec_iq=1 and full_dec=0: read pointer incremented modulo iq_size.
REQ-018: Push while iq_full=1 SHALL be dropped with no state change, even if a pop occurs in the same cycle; iq_full is derived from the registered count only.
REQ-019: Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020: Pointers SHALL wrap from iq_size-1 to 0 with no gap or duplicated entry.
REQ-021: Head outputs SHALL be combinational from the entry at the read pointer; when empty they SHALL drive 0 and load_dec_iq=0.
REQ-022: Pop when empty SHALL be impossible; full_dec is ignored while load_dec_iq=0.
REQ-023: flush_iq=1 SHALL take priority over push and pop; at that edge count and both pointers SHALL go to 0, and same-cycle push data SHALL be discarded.
REQ-024: Latency SHALL be one cycle from push edge to load_dec_iq=1 for that entry when the queue was empty (bypass disabled).
REQ-025: Entries SHALL leave in push order; no reordering.

Reset
REQ-026: rst=0 SHALL immediately, without a clock, clear count, read pointer and write pointer to 0.
REQ-027: During and after reset, iq_full=0, load_dec_iq=0, instruction_iq_head=0, PC_iq_head=0 and iq_count=0.
REQ-028: Reset mid-operation SHALL discard all entries; storage contents need not be cleared.

Configuration
REQ-029: Macro IQ_BYPASS_EN SHALL control empty-queue bypass.
REQ-030: With IQ_BYPASS_EN defined, when count==0, flush_iq=0 and load_iq=1, the head outputs SHALL show inst_in/pc_in with load_dec_iq=1 in the same cycle. If full_dec=0, the entry SHALL be consumed without being written and count stays 0. If full_dec=1, a normal push occurs.
REQ-031: Without IQ_BYPASS_EN, there SHALL be no combinational path from inst_in, pc_in or load_iq to any output, and REQ-024 latency applies.

Verification
REQ-032: Reset, then push 8 words 0x00000013+k with PC 0x60+4k, full_dec=1 -> iq_full=1 and iq_count=8 after the 8th edge; a 9th push is dropped.
REQ-033: From the full state, hold load_iq=1 and full_dec=0 for 8 cycles -> head PCs 0x60..0x7C in order; push dropped on the first cycle only, then accepted (count stays 7).
REQ-034: Run 20 push/pop cycles with count held at 3 -> pointers wrap, head sequence matches push sequence exactly.
REQ-035: With 5 entries, assert flush_iq together with load_iq=1 and full_dec=0 -> next cycle iq_count=0 and load_dec_iq=0; the flushed-cycle push is absent.
REQ-036: Drop rst to 0 between edges with 4 entries -> outputs at reset values before the next clk edge.
REQ-037: With IQ_BYPASS_EN defined and the queue empty, push 0x00500093 with full_dec=0 -> same-cycle instruction_iq_head=0x00500093, load_dec_iq=1, iq_count stays 0.
